// File: rtl/bcd_countdown.sv
// bcd_countdown: two-digit BCD down counter (99..00) with load, start and
// per-cycle decrement enable. Flags terminal count with the count_eq_0 level
// and a one-cycle expired pulse.
// Optional build macro BCD_COUNTDOWN_WRAP_EN: the count wraps from 00 to 99
// and stays in RUN instead of stopping in DONE.
module bcd_countdown (
   input  logic       clock,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] load_val,
   input  logic       start,
   input  logic       dec,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic       count_eq_0,
   output logic       running,
   output logic       expired
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state;

   // A loaded digit above 9 is forced to 9 so the outputs always stay BCD.
   function automatic logic [3:0] clamp_digit(input logic [3:0] d);
      return (d > 4'd9) ? 4'd9 : d;
   endfunction

   // The terminal flag comes straight from the digit registers.
   assign count_eq_0 = (tens == 4'd0) && (ones == 4'd0);

   // Control FSM and count registers, priority load > start > dec.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         tens    <= 4'd0;
         ones    <= 4'd0;
         running <= 1'b0;
         expired <= 1'b0;
      end else begin
         expired <= 1'b0;
         if (load) begin
            tens    <= clamp_digit(load_val[7:4]);
            ones    <= clamp_digit(load_val[3:0]);
            state   <= IDLE;
            running <= 1'b0;
         end else if (start && (state == IDLE) && !count_eq_0) begin
            state   <= RUN;
            running <= 1'b1;
         end else if (dec && (state == RUN)) begin
            if (ones != 4'd0) begin
               ones <= ones - 4'd1;
               // 01 -> 00 is the terminal transition.
               if ((tens == 4'd0) && (ones == 4'd1)) begin
                  expired <= 1'b1;
`ifndef BCD_COUNTDOWN_WRAP_EN
                  state   <= DONE;
                  running <= 1'b0;
`endif
               end
            end else if (tens != 4'd0) begin
               // Borrow from the tens digit.
               ones <= 4'd9;
               tens <= tens - 4'd1;
            end else begin
`ifdef BCD_COUNTDOWN_WRAP_EN
               // 00 wraps silently to 99.
               ones <= 4'd9;
               tens <= 4'd9;
`else
               // RUN at 00 cannot occur here; hold the count.
               ones <= ones;
               tens <= tens;
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_bcd_countdown.sv
// Testbench for bcd_countdown: directed scenarios plus randomized traffic,
// checked against a count/state reference model in plain arithmetic.
module tb_bcd_countdown;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       load = 1'b0;
   logic [7:0] load_val = 8'h00;
   logic       start = 1'b0;
   logic       dec = 1'b0;
   logic [3:0] tens, ones;
   logic       count_eq_0, running, expired;

   int compared = 0;
   int mismatched = 0;

`ifdef BCD_COUNTDOWN_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   // Reference model: count as integer 0..99, state 0=idle 1=run 2=done.
   int m_cnt = 0;
   int m_st = 0;
   bit m_exp = 1'b0;

   bcd_countdown dut (
      .clock(clock), .reset(reset), .load(load), .load_val(load_val),
      .start(start), .dec(dec), .tens(tens), .ones(ones),
      .count_eq_0(count_eq_0), .running(running), .expired(expired)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int clampd(input int d);
      return (d > 9) ? 9 : d;
   endfunction

   task automatic model_reset();
      m_cnt = 0; m_st = 0; m_exp = 1'b0;
   endtask

   task automatic model_edge(input bit l, input logic [7:0] lv, input bit s, input bit d);
      m_exp = 1'b0;
      if (l) begin
         m_cnt = clampd(int'(lv[7:4])) * 10 + clampd(int'(lv[3:0]));
         m_st  = 0;
      end else if (s && m_st == 0 && m_cnt != 0) begin
         m_st = 1;
      end else if (d && m_st == 1) begin
         if (m_cnt == 0) m_cnt = 99;
         else begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
               m_exp = 1'b1;
               if (!WRAP) m_st = 2;
            end
         end
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".tens"}, {4'd0, tens}, 8'(m_cnt / 10));
      check({tag, ".ones"}, {4'd0, ones}, 8'(m_cnt % 10));
      check({tag, ".eq0"}, {7'd0, count_eq_0}, {7'd0, m_cnt == 0});
      check({tag, ".run"}, {7'd0, running}, {7'd0, m_st == 1});
      check({tag, ".exp"}, {7'd0, expired}, {7'd0, m_exp});
   endtask

   // One clock: drive inputs, take the edge, advance model, check after edge.
   task automatic step(input string tag, input bit l, input logic [7:0] lv, input bit s, input bit d);
      load = l; load_val = lv; start = s; dec = d;
      @(posedge clock);
      model_edge(l, lv, s, d);
      #1;
      check_all(tag);
   endtask

   task automatic async_reset(input string tag);
      #2 reset = 1'b1;
      #1;
      model_reset();
      check_all(tag);
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      int first_zero;
      // Reset state
      #12;
      model_reset();
      check_all("reset");
      @(negedge clock);
      reset = 1'b0;

      // Reset mid-run
      step("mr_load", 1, 8'h25, 0, 0);
      step("mr_start", 0, 8'h00, 1, 0);
      for (int i = 0; i < 3; i++) step("mr_dec", 0, 8'h00, 0, 1);
      check("mr_22", {tens, ones}, 8'h22);
      async_reset("mr_async");
      step("mr_dec_after", 0, 8'h00, 0, 1);
      step("mr_start_after", 0, 8'h00, 1, 0);

      // Borrow
      step("bw_load", 1, 8'h10, 0, 0);
      step("bw_start", 0, 8'h00, 1, 0);
      step("bw_dec", 0, 8'h00, 0, 1);
      check("bw_09", {tens, ones}, 8'h09);
      first_zero = 0;
      for (int i = 2; i <= 100; i++) begin
         step("bw_run", 0, 8'h00, 0, 1);
         if (count_eq_0 && first_zero == 0) first_zero = i;
      end
      check("bw_first_zero", 8'(first_zero), 8'd10);

      // Terminal
      step("tm_load", 1, 8'h02, 0, 0);
      step("tm_start", 0, 8'h00, 1, 0);
      step("tm_dec1", 0, 8'h00, 0, 1);
      step("tm_dec2", 0, 8'h00, 0, 1);
      check("tm_expired", {7'd0, expired}, 8'd1);
      check("tm_count", {tens, ones}, 8'h00);
      check("tm_running", {7'd0, running}, {7'd0, WRAP});
      step("tm_extra", 0, 8'h00, 0, 1);
      check("tm_extra_exp", {7'd0, expired}, 8'd0);
      check("tm_extra_cnt", {tens, ones}, WRAP ? 8'h99 : 8'h00);
      step("tm_idle", 0, 8'h00, 0, 0);

      // Clamp and ignore-start
      step("cl_load", 1, 8'hAF, 0, 0);
      check("cl_99", {tens, ones}, 8'h99);
      step("cl_loadA0", 1, 8'h5C, 0, 0);
      check("cl_59", {tens, ones}, 8'h59);
      step("cl_load0", 1, 8'h00, 0, 0);
      step("cl_start0", 0, 8'h00, 1, 0);
      check("cl_norun", {7'd0, running}, 8'd0);

      // Priority: load and dec together while running at 45
      step("pr_load", 1, 8'h45, 0, 0);
      step("pr_start", 0, 8'h00, 1, 1);
      check("pr_start_nodec", {tens, ones}, 8'h45);
      step("pr_both", 1, 8'h30, 0, 1);
      check("pr_30", {tens, ones}, 8'h30);
      check("pr_idle", {7'd0, running}, 8'd0);

      // Wrap scenario (model gives the stop behaviour when not enabled)
      step("wr_load", 1, 8'h01, 0, 0);
      step("wr_start", 0, 8'h00, 1, 0);
      step("wr_dec", 0, 8'h00, 0, 1);
      check("wr_exp", {7'd0, expired}, 8'd1);
      step("wr_dec2", 0, 8'h00, 0, 1);

      // Randomized traffic; start only offered when dec is low
      for (int i = 0; i < 3000; i++) begin
         bit l, s, d;
         logic [7:0] lv;
         l  = ($urandom_range(0, 99) < 3);
         d  = ($urandom_range(0, 99) < 70);
         s  = !d && ($urandom_range(0, 99) < 20);
         lv = 8'($urandom);
         if ($urandom_range(0, 3) != 0)
            lv = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
         step("rnd", l, lv, s, d);
         if ($urandom_range(0, 999) < 3) async_reset("rnd_reset");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
